// File: rtl/c17_key_loader.sv
// Serial MSB-first key loader for the cyclic-obfuscated c17 netlist: holds a loop-free default
// until a full key is accepted, then locks it until reset. Optional parity via C17_KEY_PARITY_EN.
module c17_key_loader #(
   parameter int               KEY_W       = 2,
   parameter logic [KEY_W-1:0] KEY_DEFAULT = '0,
   parameter int               CNT_W       = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_start,
   input  logic             sin_valid,
   input  logic             sin_data,
   output logic             sin_ready,
   output logic [KEY_W-1:0] key_out,
   output logic             key_valid,
   output logic             busy,
   output logic             err
);

`ifdef C17_KEY_PARITY_EN
   localparam int SH_W = KEY_W + 1;
`else
   localparam int SH_W = KEY_W;
`endif
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SH_W - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, CHECK, LOCKED} state_t;

   state_t           state, state_nxt;
   logic [SH_W-1:0]  shreg;
   logic [CNT_W-1:0] cnt;
   logic             accept;
   logic             check_ok;

   assign sin_ready = (state == SHIFT);
   assign accept    = sin_valid & sin_ready;
   assign busy      = (state == SHIFT) || (state == CHECK);
   assign key_valid = (state == LOCKED);

`ifdef C17_KEY_PARITY_EN
   // Even parity: key bits plus trailing parity bit must hold an even number of ones.
   assign check_ok = ~^shreg;
`else
   assign check_ok = 1'b1;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (load_start) state_nxt = SHIFT;
         SHIFT:   if (accept && (cnt == CNT_LAST)) state_nxt = CHECK;
         CHECK:   state_nxt = check_ok ? LOCKED : IDLE;
         LOCKED:  state_nxt = LOCKED;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // key_out is only ever written from the complete shift register at CHECK, so no partial key leaks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg   <= '0;
         cnt     <= '0;
         key_out <= KEY_DEFAULT;
      end else begin
         if ((state == IDLE) && load_start) begin
            shreg <= '0;
            cnt   <= '0;
         end else if (accept) begin
            shreg <= {shreg[SH_W-2:0], sin_data};
            cnt   <= cnt + CNT_W'(1);
         end
         if ((state == CHECK) && check_ok)
            key_out <= shreg[SH_W-1 -: KEY_W];
      end
   end

`ifdef C17_KEY_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err <= 1'b0;
      else if ((state == IDLE) && load_start)
         err <= 1'b0;
      else if ((state == CHECK) && !check_ok)
         err <= 1'b1;
   end
`else
   assign err = 1'b0;
`endif

endmodule
